// File: rtl/reg_dump_if.sv
// Valid/ready stream carrying one dumped register value and its index.
// The dumper drives the master side, the consumer the slave side.
interface reg_dump_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_idx;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        output out_ready
    );
endinterface

// File: rtl/reg_dump.sv
// Debug register-file dumper: walks registers FIRST_REG..LAST_REG through a
// combinational read port and streams each captured value over valid/ready.
module reg_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        abort_i,
    output logic [4:0]  rf_addr_o,
    input  logic [31:0] rf_data_i,
    reg_dump_if.master  out_if,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  out_idx_q, out_idx_d;
    logic        handshake;

    assign handshake = out_if.out_valid && out_if.out_ready;

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= FIRST_IDX;
            data_q    <= '0;
            out_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            out_idx_q <= out_idx_d;
        end
    end

    // NOTE: every signal gets a hold default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        out_idx_d = out_idx_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH;
                    idx_d   = FIRST_IDX;
                end
            end
            FETCH: begin
                // Snapshot is the pre-edge read, so a write on this same edge is not seen.
                data_d    = rf_data_i;
                out_idx_d = idx_q;
                state_d   = abort_i ? IDLE : SEND;
            end
            SEND: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (handshake) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        out_if.out_valid = (state_q == SEND);
        busy_o           = (state_q != IDLE);
        done_o           = (state_q == DONE);
    end

    assign rf_addr_o       = idx_q;
    assign out_if.out_data = data_q;
    assign out_if.out_idx  = out_idx_q;

endmodule
